// File: rtl/fft_pkg.sv
// Shared constants and state encoding for the 1024-point radix-2 FFT control path.
package fft_pkg;

    localparam int FFT_SIZE = 1024;
    localparam int N_STAGES = 10;
    localparam int N_BFLY   = 512;
    localparam int ADDR_W   = 10;
    localparam int TW_W     = 9;
    localparam int STAGE_W  = 5;
    localparam int CYCLE_W  = 9;
    localparam int WB_W     = 1 + 2 * ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/fft_wb_delay.sv
// Fixed-latency shift register carrying {valid, addrA, addrB} from read issue to write-back.
module fft_wb_delay #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 21
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] dIn,
    output logic [WIDTH-1:0] dOut
);

    genvar gi;
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic [WIDTH-1:0] q;
        if (gi == 0) begin : g_head
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) q <= '0;
                else        q <= dIn;
            end
        end else begin : g_tail
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) q <= '0;
                else        q <= g_stage[gi-1].q;
            end
        end
    end

    assign dOut = g_stage[DEPTH-1].q;

endmodule

// File: rtl/fft_stage_sequencer.sv
// Stage/cycle sequencer for the in-place radix-2 FFT: issues reads, replays them as write-backs.
// Optional feature: define FFT_SEQ_CYCLE_CNT_EN to add the runCycles activity counter output.
module fft_stage_sequencer
    import fft_pkg::*;
#(
    parameter int BFLY_LAT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [STAGE_W-1:0]  stageCount,
    output logic [CYCLE_W-1:0]  cycleCount,
    input  logic [ADDR_W-1:0]   indexA_in,
    input  logic [ADDR_W-1:0]   indexB_in,
    input  logic [TW_W-1:0]     twiddleIndex_in,
    output logic                rdEn,
    output logic [ADDR_W-1:0]   rdAddrA,
    output logic [ADDR_W-1:0]   rdAddrB,
    output logic [TW_W-1:0]     twAddr,
    output logic                wrEn,
    output logic [ADDR_W-1:0]   wrAddrA,
    output logic [ADDR_W-1:0]   wrAddrB
`ifdef FFT_SEQ_CYCLE_CNT_EN
    ,
    output logic [15:0]         runCycles
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'(IDLE);
    localparam logic [1:0] ST_ISSUE = 2'(ISSUE);
    localparam logic [1:0] ST_DRAIN = 2'(DRAIN);
    localparam logic [1:0] ST_DONE  = 2'(DONE);

    localparam logic [CYCLE_W-1:0] LAST_CYCLE = CYCLE_W'(N_BFLY - 1);
    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(N_STAGES - 1);
    localparam logic [3:0]         DRAIN_LOAD = 4'(BFLY_LAT);

    logic [1:0]      state;
    logic [3:0]      drainCnt;
    logic [WB_W-1:0] wbIn;
    logic [WB_W-1:0] wbOut;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            stageCount <= '0;
            cycleCount <= '0;
            drainCnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_ISSUE;
                        stageCount <= '0;
                        cycleCount <= '0;
                    end
                end
                ST_ISSUE: begin
                    if (cycleCount == LAST_CYCLE) begin
                        cycleCount <= '0;
                        drainCnt   <= DRAIN_LOAD;
                        state      <= ST_DRAIN;
                    end else begin
                        cycleCount <= cycleCount + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    drainCnt <= drainCnt - 1'b1;
                    // Leaving on count 1 lets the stage's last write-back share this cycle.
                    if (drainCnt == 4'd1) begin
                        if (stageCount == LAST_STAGE) begin
                            stageCount <= '0;
                            state      <= ST_DONE;
                        end else begin
                            stageCount <= stageCount + 1'b1;
                            state      <= ST_ISSUE;
                        end
                    end
                end
                ST_DONE: begin
                    stageCount <= '0;
                    cycleCount <= '0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy    = (state != ST_IDLE);
    assign done    = (state == ST_DONE);
    assign rdEn    = (state == ST_ISSUE);
    assign rdAddrA = rdEn ? indexA_in       : '0;
    assign rdAddrB = rdEn ? indexB_in       : '0;
    assign twAddr  = rdEn ? twiddleIndex_in : '0;

    assign wbIn = {rdEn, rdAddrA, rdAddrB};

    fft_wb_delay #(
        .DEPTH (BFLY_LAT),
        .WIDTH (WB_W)
    ) u_wbDelay (
        .clk   (clk),
        .rst_n (rst_n),
        .dIn   (wbIn),
        .dOut  (wbOut)
    );

    assign wrEn    = wbOut[WB_W-1];
    assign wrAddrA = wrEn ? wbOut[2*ADDR_W-1:ADDR_W] : '0;
    assign wrAddrB = wrEn ? wbOut[ADDR_W-1:0]        : '0;

`ifdef FFT_SEQ_CYCLE_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            runCycles <= '0;
        end else if (state == ST_IDLE && start) begin
            runCycles <= '0;
        end else if (state == ST_ISSUE || state == ST_DRAIN) begin
            runCycles <= runCycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench: three sequencers (BFLY_LAT 4, 1, 15) each driven by a behavioural address generator.
module tb_fft_stage_sequencer;

    typedef struct {
        int         cyc;
        logic [9:0] a;
        logic [9:0] b;
        logic [8:0] tw;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic       start      [3];
    logic       busy       [3];
    logic       done       [3];
    logic       rdEn       [3];
    logic       wrEn       [3];
    logic [4:0] stageCount [3];
    logic [8:0] cycleCount [3];
    logic [9:0] idxA       [3];
    logic [9:0] idxB       [3];
    logic [8:0] twIdx      [3];
    logic [9:0] rdAddrA    [3];
    logic [9:0] rdAddrB    [3];
    logic [8:0] twAddr     [3];
    logic [9:0] wrAddrA    [3];
    logic [9:0] wrAddrB    [3];
`ifdef FFT_SEQ_CYCLE_CNT_EN
    logic [15:0] runCycles [3];
`endif

    exp_t rdQ [3][$];
    exp_t wrQ [3][$];
    int   rdErr   [3];
    int   wrErr   [3];
    int   zeroErr [3];

    function automatic int latOf(int i);
        return (i == 0) ? 4 : (i == 1) ? 1 : 15;
    endfunction

    function automatic int halfOf(int s);
        return (s >= 0 && s <= 9) ? (512 >> s) : 0;
    endfunction

    // Behavioural in-place radix-2 address generator: partner spacing halves each stage.
    function automatic logic [9:0] genA(int s, int c);
        int h;
        h = halfOf(s);
        if (h == 0) return 10'd0;
        return 10'((c / h) * 2 * h + (c % h));
    endfunction

    function automatic logic [9:0] genB(int s, int c);
        int h;
        h = halfOf(s);
        if (h == 0) return 10'd0;
        return 10'((c / h) * 2 * h + (c % h) + h);
    endfunction

    function automatic logic [8:0] genTw(int s, int c);
        int h;
        h = halfOf(s);
        if (h == 0) return 9'd0;
        return 9'((c % h) << s);
    endfunction

    genvar gi;
    for (gi = 0; gi < 3; gi++) begin : g
        localparam int LAT = (gi == 0) ? 4 : (gi == 1) ? 1 : 15;
        assign idxA[gi]  = genA(int'(stageCount[gi]), int'(cycleCount[gi]));
        assign idxB[gi]  = genB(int'(stageCount[gi]), int'(cycleCount[gi]));
        assign twIdx[gi] = genTw(int'(stageCount[gi]), int'(cycleCount[gi]));

        fft_stage_sequencer #(.BFLY_LAT(LAT)) dut (
            .clk             (clk),
            .rst_n           (rst_n),
            .start           (start[gi]),
            .busy            (busy[gi]),
            .done            (done[gi]),
            .stageCount      (stageCount[gi]),
            .cycleCount      (cycleCount[gi]),
            .indexA_in       (idxA[gi]),
            .indexB_in       (idxB[gi]),
            .twiddleIndex_in (twIdx[gi]),
            .rdEn            (rdEn[gi]),
            .rdAddrA         (rdAddrA[gi]),
            .rdAddrB         (rdAddrB[gi]),
            .twAddr          (twAddr[gi]),
            .wrEn            (wrEn[gi]),
            .wrAddrA         (wrAddrA[gi]),
            .wrAddrB         (wrAddrB[gi])
`ifdef FFT_SEQ_CYCLE_CNT_EN
            ,
            .runCycles       (runCycles[gi])
`endif
        );
    end

    // Expected reads and write-backs of a whole transform whose start is high in cycle p.
    task automatic pushRun(input int i, input int p);
        int lat;
        int t;
        lat = latOf(i);
        for (int s = 0; s < 10; s++) begin
            for (int c = 0; c < 512; c++) begin
                t = p + 1 + s * (512 + lat) + c;
                rdQ[i].push_back('{t, genA(s, c), genB(s, c), genTw(s, c)});
                wrQ[i].push_back('{t + lat, genA(s, c), genB(s, c), 9'd0});
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (rdEn[i] === 1'b1) begin
                if (rdQ[i].size() == 0) begin
                    rdErr[i]++;
                end else begin
                    e = rdQ[i].pop_front();
                    if (e.cyc != cyc || rdAddrA[i] !== e.a || rdAddrB[i] !== e.b || twAddr[i] !== e.tw)
                        rdErr[i]++;
                end
            end else if (rdAddrA[i] !== 10'd0 || rdAddrB[i] !== 10'd0 || twAddr[i] !== 9'd0) begin
                zeroErr[i]++;
            end
            if (wrEn[i] === 1'b1) begin
                if (wrQ[i].size() == 0) begin
                    wrErr[i]++;
                end else begin
                    e = wrQ[i].pop_front();
                    if (e.cyc != cyc || wrAddrA[i] !== e.a || wrAddrB[i] !== e.b)
                        wrErr[i]++;
                end
            end else if (wrAddrA[i] !== 10'd0 || wrAddrB[i] !== 10'd0) begin
                zeroErr[i]++;
            end
        end
    end

    task automatic waitDone(input int i, input int budget, output int atCyc);
        atCyc = -1;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (done[i] === 1'b1) begin
                atCyc = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) start[i] = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if ({busy[i], done[i], rdEn[i], wrEn[i], stageCount[i], cycleCount[i],
                 rdAddrA[i], rdAddrB[i], twAddr[i], wrAddrA[i], wrAddrB[i]} !== '0) begin
                fails++;
                $display("FAIL reset_outputs inst%0d: busy=%b done=%b rdEn=%b wrEn=%b stage=%0d cycle=%0d, required all zero",
                         i, busy[i], done[i], rdEn[i], wrEn[i], stageCount[i], cycleCount[i]);
            end
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        tests++; if (busy[0] !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b required 0", busy[0]); end
        tests++; if (rdEn[0] !== 1'b0) begin fails++; $display("FAIL idle_rdEn: got %b required 0", rdEn[0]); end
        tests++; if (wrEn[0] !== 1'b0) begin fails++; $display("FAIL idle_wrEn: got %b required 0", wrEn[0]); end
        tests++; if (stageCount[0] !== 5'd0) begin fails++; $display("FAIL idle_stage: got %0d required 0", stageCount[0]); end
        tests++; if (cycleCount[0] !== 9'd0) begin fails++; $display("FAIL idle_cycle: got %0d required 0", cycleCount[0]); end
        $display("[TB] reset/idle checked");
    endtask

    task automatic test_single_run();
        int p, d, r0, w0, z0, n;
        r0 = rdErr[0]; w0 = wrErr[0]; z0 = zeroErr[0];
        @(posedge clk); #1;
        p = cyc;
        pushRun(0, p);
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        @(negedge clk);
        tests++;
        if (cyc != p + 1 || rdEn[0] !== 1'b1 || rdAddrA[0] !== 10'd0 || rdAddrB[0] !== 10'd512 || twAddr[0] !== 9'd0) begin
            fails++;
            $display("FAIL first_read: rdEn=%b A=%0d B=%0d tw=%0d, required rdEn=1 A=0 B=512 tw=0", rdEn[0], rdAddrA[0], rdAddrB[0], twAddr[0]);
        end
        repeat (4) @(negedge clk);
        tests++;
        if (wrEn[0] !== 1'b1 || wrAddrA[0] !== 10'd0 || wrAddrB[0] !== 10'd512) begin
            fails++;
            $display("FAIL first_write: wrEn=%b A=%0d B=%0d, required wrEn=1 A=0 B=512", wrEn[0], wrAddrA[0], wrAddrB[0]);
        end
        n = 0;
        while (n < 6000 && !(rdEn[0] === 1'b1 && stageCount[0] === 5'd9)) begin @(negedge clk); n++; end
        tests++;
        if (cyc != p + 1 + 9 * 516 || rdAddrA[0] !== 10'd0 || rdAddrB[0] !== 10'd1) begin
            fails++;
            $display("FAIL stage9_first: cyc=%0d A=%0d B=%0d, required cyc=%0d A=0 B=1", cyc - p, rdAddrA[0], rdAddrB[0], 1 + 9 * 516);
        end
        n = 0;
        while (n < 1000 && !(rdEn[0] === 1'b1 && cycleCount[0] === 9'd511)) begin @(negedge clk); n++; end
        tests++;
        if (rdAddrA[0] !== 10'd1022 || rdAddrB[0] !== 10'd1023) begin
            fails++;
            $display("FAIL stage9_last: A=%0d B=%0d, required A=1022 B=1023", rdAddrA[0], rdAddrB[0]);
        end
        waitDone(0, 1000, d);
        tests++;
        if (d != p + 5161) begin
            fails++;
            $display("FAIL done_time_lat4: got start+%0d required start+5161", d - p);
        end
`ifdef FFT_SEQ_CYCLE_CNT_EN
        tests++;
        if (runCycles[0] !== 16'd5160) begin fails++; $display("FAIL runCycles_single: got %0d required 5160", runCycles[0]); end
`endif
        @(negedge clk); #1;
        tests++;
        if (done[0] !== 1'b0 || busy[0] !== 1'b0) begin
            fails++;
            $display("FAIL done_pulse: done=%b busy=%b after DONE, required 0 0", done[0], busy[0]);
        end
        tests++;
        if (rdErr[0] - r0 != 0 || wrErr[0] - w0 != 0 || zeroErr[0] - z0 != 0 || rdQ[0].size() != 0 || wrQ[0].size() != 0) begin
            fails++;
            $display("FAIL scoreboard_lat4: rdErr=%0d wrErr=%0d zeroErr=%0d left rd=%0d wr=%0d, required all 0",
                     rdErr[0] - r0, wrErr[0] - w0, zeroErr[0] - z0, rdQ[0].size(), wrQ[0].size());
        end
        $display("[TB] single run BFLY_LAT=4 done at start+%0d", d - p);
    endtask

    task automatic test_back_to_back();
        int p, d1, d2, r0, w0, z0;
        r0 = rdErr[0]; w0 = wrErr[0]; z0 = zeroErr[0];
        @(posedge clk); #1;
        p = cyc;
        pushRun(0, p);
        pushRun(0, p + 5162);
        start[0] = 1'b1;
        waitDone(0, 6000, d1);
        tests++;
        if (d1 != p + 5161) begin fails++; $display("FAIL b2b_done1: got start+%0d required start+5161", d1 - p); end
`ifdef FFT_SEQ_CYCLE_CNT_EN
        tests++;
        if (runCycles[0] !== 16'd5160) begin fails++; $display("FAIL runCycles_run1: got %0d required 5160", runCycles[0]); end
`endif
        @(negedge clk);
        tests++;
        if (busy[0] !== 1'b0 || rdEn[0] !== 1'b0) begin
            fails++;
            $display("FAIL b2b_idle_gap: busy=%b rdEn=%b, required 0 0", busy[0], rdEn[0]);
        end
        @(negedge clk);
        tests++;
        if (rdEn[0] !== 1'b1 || stageCount[0] !== 5'd0 || cycleCount[0] !== 9'd0) begin
            fails++;
            $display("FAIL b2b_relaunch: rdEn=%b stage=%0d cycle=%0d, required 1 0 0", rdEn[0], stageCount[0], cycleCount[0]);
        end
        waitDone(0, 6000, d2);
        start[0] = 1'b0;
        tests++;
        if (d2 != p + 10323) begin fails++; $display("FAIL b2b_done2: got start+%0d required start+10323", d2 - p); end
`ifdef FFT_SEQ_CYCLE_CNT_EN
        tests++;
        if (runCycles[0] !== 16'd5160) begin fails++; $display("FAIL runCycles_run2: got %0d required 5160", runCycles[0]); end
`endif
        repeat (4) @(negedge clk);
        #1;
        tests++;
        if (busy[0] !== 1'b0 || rdErr[0] - r0 != 0 || wrErr[0] - w0 != 0 || zeroErr[0] - z0 != 0 || rdQ[0].size() != 0 || wrQ[0].size() != 0) begin
            fails++;
            $display("FAIL scoreboard_b2b: busy=%b rdErr=%0d wrErr=%0d zeroErr=%0d left rd=%0d wr=%0d, required 0",
                     busy[0], rdErr[0] - r0, wrErr[0] - w0, zeroErr[0] - z0, rdQ[0].size(), wrQ[0].size());
        end
        $display("[TB] back-to-back runs done at start+%0d and start+%0d", d1 - p, d2 - p);
    endtask

    task automatic test_reset_mid_run();
        int p, d, n, r0, w0, z0;
        @(posedge clk); #1;
        p = cyc;
        pushRun(0, p);
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        n = 0;
        while (n < 3000 && !(stageCount[0] === 5'd3 && cycleCount[0] === 9'd100)) begin @(negedge clk); n++; end
        tests++;
        if (n >= 3000) begin fails++; $display("FAIL reach_stage3: timed out at stage=%0d cycle=%0d", stageCount[0], cycleCount[0]); end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({busy[0], done[0], rdEn[0], wrEn[0], stageCount[0], cycleCount[0],
             rdAddrA[0], rdAddrB[0], twAddr[0], wrAddrA[0], wrAddrB[0]} !== '0) begin
            fails++;
            $display("FAIL async_clear: busy=%b rdEn=%b wrEn=%b stage=%0d cycle=%0d wrA=%0d, required all zero",
                     busy[0], rdEn[0], wrEn[0], stageCount[0], cycleCount[0], wrAddrA[0]);
        end
        rdQ[0].delete();
        wrQ[0].delete();
        r0 = rdErr[0]; w0 = wrErr[0]; z0 = zeroErr[0];
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        tests++;
        if (wrErr[0] - w0 != 0 || rdErr[0] - r0 != 0 || busy[0] !== 1'b0) begin
            fails++;
            $display("FAIL no_stale_writeback: wrErr=%0d rdErr=%0d busy=%b, required 0 0 0", wrErr[0] - w0, rdErr[0] - r0, busy[0]);
        end
        @(posedge clk); #1;
        p = cyc;
        pushRun(0, p);
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        @(negedge clk);
        tests++;
        if (rdEn[0] !== 1'b1 || stageCount[0] !== 5'd0 || cycleCount[0] !== 9'd0) begin
            fails++;
            $display("FAIL restart_stage0: rdEn=%b stage=%0d cycle=%0d, required 1 0 0", rdEn[0], stageCount[0], cycleCount[0]);
        end
        waitDone(0, 6000, d);
        @(negedge clk); #1;
        tests++;
        if (d != p + 5161 || rdErr[0] - r0 != 0 || wrErr[0] - w0 != 0 || zeroErr[0] - z0 != 0 || rdQ[0].size() != 0 || wrQ[0].size() != 0) begin
            fails++;
            $display("FAIL restart_run: done at start+%0d rdErr=%0d wrErr=%0d zeroErr=%0d, required start+5161 and 0 errors",
                     d - p, rdErr[0] - r0, wrErr[0] - w0, zeroErr[0] - z0);
        end
        $display("[TB] mid-run reset and restart checked");
    endtask

    task automatic test_latency_extremes();
        int p, d1, d15, r1, w1, z1, r2, w2, z2;
        r1 = rdErr[1]; w1 = wrErr[1]; z1 = zeroErr[1];
        r2 = rdErr[2]; w2 = wrErr[2]; z2 = zeroErr[2];
        @(posedge clk); #1;
        p = cyc;
        pushRun(1, p);
        pushRun(2, p);
        start[1] = 1'b1;
        start[2] = 1'b1;
        @(posedge clk); #1;
        start[1] = 1'b0;
        start[2] = 1'b0;
        d1 = -1;
        d15 = -1;
        for (int n = 0; n < 6000 && d15 < 0; n++) begin
            @(negedge clk);
            if (done[1] === 1'b1 && d1 < 0) d1 = cyc;
            if (done[2] === 1'b1 && d15 < 0) d15 = cyc;
        end
        @(negedge clk); #1;
        tests++;
        if (d1 != p + 5131) begin fails++; $display("FAIL done_time_lat1: got start+%0d required start+5131", d1 - p); end
        tests++;
        if (d15 != p + 5271) begin fails++; $display("FAIL done_time_lat15: got start+%0d required start+5271", d15 - p); end
        tests++;
        if (rdErr[1] - r1 != 0 || wrErr[1] - w1 != 0 || zeroErr[1] - z1 != 0 || rdQ[1].size() != 0 || wrQ[1].size() != 0) begin
            fails++;
            $display("FAIL scoreboard_lat1: rdErr=%0d wrErr=%0d zeroErr=%0d left rd=%0d wr=%0d, required all 0",
                     rdErr[1] - r1, wrErr[1] - w1, zeroErr[1] - z1, rdQ[1].size(), wrQ[1].size());
        end
        tests++;
        if (rdErr[2] - r2 != 0 || wrErr[2] - w2 != 0 || zeroErr[2] - z2 != 0 || rdQ[2].size() != 0 || wrQ[2].size() != 0) begin
            fails++;
            $display("FAIL scoreboard_lat15: rdErr=%0d wrErr=%0d zeroErr=%0d left rd=%0d wr=%0d, required all 0",
                     rdErr[2] - r2, wrErr[2] - w2, zeroErr[2] - z2, rdQ[2].size(), wrQ[2].size());
        end
        $display("[TB] BFLY_LAT=1 done at start+%0d, BFLY_LAT=15 done at start+%0d", d1 - p, d15 - p);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rdErr[i] = 0;
            wrErr[i] = 0;
            zeroErr[i] = 0;
        end
        test_reset();
        test_single_run();
        test_back_to_back();
        test_reset_mid_run();
        test_latency_extremes();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
